// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencer.
package counter_seq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_NREQ  = 2;

    typedef enum logic [1:0] {
        OP_LOAD      = 2'd0,
        OP_COUNTDOWN = 2'd1,
        OP_HALVE     = 2'd2,
        OP_LOAD_RUN  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDec,
        StHalve,
        StDone
    } state_e;

    // First sequence state entered after a command is granted.
    function automatic state_e first_state(input op_e op);
        unique case (op)
            OP_COUNTDOWN: return StDec;
            OP_HALVE:     return StHalve;
            default:      return StLoad;
        endcase
    endfunction

endpackage

// File: rtl/counter_sequencer_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the winner on accept.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned IdxW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_i,
    input  logic            accept_i,
    output logic            valid_o,
    output logic [IdxW-1:0] idx_o,
    output logic [NREQ-1:0] gnt_o
);

    logic [IdxW-1:0] ptr_q, ptr_d;

    function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[IdxW-1:0];
    endfunction

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!valid_o && req_i[wrap_idx(ptr_q, i)]) begin
                valid_o = 1'b1;
                idx_o   = wrap_idx(ptr_q, i);
            end
        end
        gnt_o = valid_o ? (NREQ'(1) << idx_o) : '0;
        ptr_d = ptr_q;
        if (accept_i && valid_o) begin
            ptr_d = (32'(idx_o) == NREQ - 1) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer front-end for the load/decrement/halve counter datapath.
// Optional countdown watchdog enabled by defining COUNTER_SEQ_TIMEOUT_EN.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned NREQ           = DEFAULT_NREQ,
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned IdW = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [IdW-1:0]        done_id,
    output logic [WIDTH-1:0]      done_count,
    output logic                  done_err,
    output logic [WIDTH-1:0]      cnt_in,
    output logic                  cnt_latch,
    output logic                  cnt_dec,
    output logic                  cnt_div,
    input  logic [WIDTH-1:0]      cnt_count
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rep_q, rep_d;
    logic [IdW-1:0]   id_q, id_d;

    logic             arb_valid;
    logic [IdW-1:0]   arb_idx;
    logic [NREQ-1:0]  arb_gnt;

`ifdef COUNTER_SEQ_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WdW-1:0] wdog_q, wdog_d;
    logic           err_q, err_d;
`endif

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req_valid),
        .accept_i (state_q == StIdle),
        .valid_o  (arb_valid),
        .idx_o    (arb_idx),
        .gnt_o    (arb_gnt)
    );

    // Gated by reset so no grant is visible while reset is held.
    assign req_ready = ((state_q == StIdle) && reset) ? arb_gnt : '0;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        rep_d      = rep_q;
        id_d       = id_q;
        cnt_in     = '0;
        cnt_latch  = 1'b0;
        cnt_dec    = 1'b0;
        cnt_div    = 1'b0;
        done_valid = 1'b0;
        done_id    = '0;
        done_count = '0;
`ifdef COUNTER_SEQ_TIMEOUT_EN
        wdog_d     = '0;
        err_d      = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    op_d    = op_e'(req_op[2*arb_idx +: 2]);
                    data_d  = req_data[WIDTH*arb_idx +: WIDTH];
                    rep_d   = req_data[WIDTH*arb_idx +: WIDTH];
                    id_d    = arb_idx;
                    state_d = first_state(op_e'(req_op[2*arb_idx +: 2]));
`ifdef COUNTER_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            StLoad: begin
                cnt_latch = 1'b1;
                cnt_in    = data_q;
                state_d   = (op_q == OP_LOAD_RUN) ? StDec : StDone;
            end
            StDec: begin
                if (cnt_count == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_dec = 1'b1;
                end
`ifdef COUNTER_SEQ_TIMEOUT_EN
                wdog_d = wdog_q + 1'b1;
                if (state_d == StDec && wdog_q == WdW'(TIMEOUT_CYCLES - 1)) begin
                    cnt_dec = 1'b0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
`endif
            end
            StHalve: begin
                if (rep_q != '0 && cnt_count != '0) begin
                    cnt_div = 1'b1;
                    rep_d   = rep_q - 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_valid = 1'b1;
                done_id    = id_q;
                done_count = cnt_count;
                if (done_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef COUNTER_SEQ_TIMEOUT_EN
    assign done_err = (state_q == StDone) ? err_q : 1'b0;
`else
    assign done_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= OP_LOAD;
            data_q  <= '0;
            rep_q   <= '0;
            id_q    <= '0;
`ifdef COUNTER_SEQ_TIMEOUT_EN
            wdog_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rep_q   <= rep_d;
            id_q    <= id_d;
`ifdef COUNTER_SEQ_TIMEOUT_EN
            wdog_q  <= wdog_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural counter datapath model.
`timescale 1ns/1ps
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned WIDTH = 8;
`ifdef COUNTER_SEQ_TIMEOUT_EN
    localparam int unsigned TMO = 10;
`else
    localparam int unsigned TMO = 255;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  done_valid;
    logic                  done_ready;
    logic                  done_id;
    logic [WIDTH-1:0]      done_count;
    logic                  done_err;
    logic [WIDTH-1:0]      cnt_in;
    logic                  cnt_latch;
    logic                  cnt_dec;
    logic                  cnt_div;
    logic [WIDTH-1:0]      cnt_count;

    int checks = 0;
    int errors = 0;

    counter_sequencer #(
        .NREQ           (NREQ),
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_id    (done_id),
        .done_count (done_count),
        .done_err   (done_err),
        .cnt_in     (cnt_in),
        .cnt_latch  (cnt_latch),
        .cnt_dec    (cnt_dec),
        .cnt_div    (cnt_div),
        .cnt_count  (cnt_count)
    );

    always #5 clk = ~clk;

    // Counter datapath model; freeze stalls decrements to provoke the watchdog.
    logic [WIDTH-1:0] cnt_q = '0;
    logic             freeze = 1'b0;
    always @(posedge clk) begin
        if (cnt_latch) cnt_q <= cnt_in;
        else if (cnt_dec && !freeze) cnt_q <= cnt_q - 1'b1;
        else if (cnt_div) cnt_q <= cnt_q >> 1;
    end
    assign cnt_count = cnt_q;

    int               lat_n, dec_n, div_n, gnt0_n, gnt1_n;
    int               excl_viol = 0;
    int               gnt_viol = 0;
    logic [WIDTH-1:0] last_in;
    logic             clr = 1'b0;
    always @(negedge clk) begin
        if (clr) begin
            lat_n = 0; dec_n = 0; div_n = 0; gnt0_n = 0; gnt1_n = 0; last_in = '0;
        end else begin
            if (cnt_latch) begin lat_n++; last_in = cnt_in; end
            if (cnt_dec) dec_n++;
            if (cnt_div) div_n++;
            if (req_ready[0]) gnt0_n++;
            if (req_ready[1]) gnt1_n++;
        end
        if (2'(cnt_latch) + 2'(cnt_dec) + 2'(cnt_div) > 2'd1) excl_viol++;
        if (!$onehot0(req_ready)) gnt_viol++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        clr = 1'b1;
        @(negedge clk);
        tick();
        clr = 1'b0;
    endtask

    // Present a command and hold it until granted; returns just after the grant edge.
    task automatic issue(input int id, input op_e op, input logic [WIDTH-1:0] data);
        logic got;
        req_valid[id]            = 1'b1;
        req_op[2*id +: 2]        = op;
        req_data[WIDTH*id +: WIDTH] = data;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = req_ready[id];
            tick();
        end
        req_valid[id] = 1'b0;
        check_eq($sformatf("grant%0d", id), 32'(got), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int id, input logic [WIDTH-1:0] cnt,
                             input logic err);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (done_valid) begin
                got = 1'b1;
                check_eq({tag, "_id"}, 32'(done_id), 32'(id));
                check_eq({tag, "_count"}, 32'(done_count), 32'(cnt));
                check_eq({tag, "_err"}, 32'(done_err), 32'(err));
            end
            tick();
        end
        check_eq({tag, "_seen"}, 32'(got), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_dvalid"}, 32'(done_valid), 32'd0);
        check_eq({tag, "_did"}, 32'(done_id), 32'd0);
        check_eq({tag, "_dcount"}, 32'(done_count), 32'd0);
        check_eq({tag, "_derr"}, 32'(done_err), 32'd0);
        check_eq({tag, "_strobes"}, {29'd0, cnt_latch, cnt_dec, cnt_div}, 32'd0);
        check_eq({tag, "_cntin"}, 32'(cnt_in), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic got;
        reset      = 1'b0;
        req_valid  = '1;
        req_op     = '0;
        req_data   = '0;
        done_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        tick();
        reset      = 1'b1;
        req_valid  = '0;
        done_ready = 1'b1;
        clear_stats();

        // Plain load
        issue(0, OP_LOAD, 8'h2A);
        wait_done("load", 0, 8'h2A, 1'b0);
        check_eq("load_latches", lat_n, 1);
        check_eq("load_cnt_in", 32'(last_in), 32'h2A);
        check_eq("load_grants", gnt0_n, 1);
        check_eq("load_decs", dec_n, 0);

        // Load then count down
        clear_stats();
        issue(1, OP_LOAD_RUN, 8'd5);
        wait_done("ldrun", 1, 8'd0, 1'b0);
        check_eq("ldrun_latches", lat_n, 1);
        check_eq("ldrun_decs", dec_n, 5);

        // Halving limited by repeat count
        issue(0, OP_LOAD, 8'h40);
        wait_done("ld40", 0, 8'h40, 1'b0);
        clear_stats();
        issue(1, OP_HALVE, 8'd3);
        wait_done("halve3", 1, 8'h08, 1'b0);
        check_eq("halve3_divs", div_n, 3);

        // Halving stopped by count reaching zero
        issue(0, OP_LOAD, 8'h03);
        wait_done("ld03", 0, 8'h03, 1'b0);
        clear_stats();
        issue(1, OP_HALVE, 8'd9);
        wait_done("halve9", 1, 8'h00, 1'b0);
        check_eq("halve9_divs", div_n, 2);

        // Countdown from zero and halve with zero repeat
        clear_stats();
        issue(0, OP_COUNTDOWN, 8'hFF);
        wait_done("cd0", 0, 8'h00, 1'b0);
        check_eq("cd0_decs", dec_n, 0);
        issue(0, OP_LOAD, 8'h10);
        wait_done("ld10", 0, 8'h10, 1'b0);
        clear_stats();
        issue(1, OP_HALVE, 8'd0);
        wait_done("halve0", 1, 8'h10, 1'b0);
        check_eq("halve0_divs", div_n, 0);

        // Both requesters streaming loads; first completion held back
        clear_stats();
        req_op     = {OP_LOAD, OP_LOAD};
        req_data   = {8'h22, 8'h11};
        req_valid  = 2'b11;
        done_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge clk);
                got = done_valid;
                if (!got) tick();
            end
            check_eq("rr_seen", 32'(got), 32'd1);
            check_eq($sformatf("rr_id%0d", k), 32'(done_id), 32'(k % 2));
            check_eq($sformatf("rr_count%0d", k), 32'(done_count),
                     (k % 2 == 0) ? 32'h11 : 32'h22);
            if (k == 0) begin
                for (int h = 0; h < 3; h++) begin
                    tick();
                    @(negedge clk);
                    check_eq("hold_valid", 32'(done_valid), 32'd1);
                    check_eq("hold_nogrant", 32'(req_ready), 32'd0);
                end
            end
            if (k == 3) req_valid = '0;
            done_ready = 1'b1;
            tick();
        end
        repeat (3) tick();
        check_eq("rr_gnt0", gnt0_n, 2);
        check_eq("rr_gnt1", gnt1_n, 2);

        // Reset in the middle of a countdown
        issue(0, OP_LOAD_RUN, 8'd9);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = cnt_dec && (cnt_count == 8'd7);
            if (!got) tick();
        end
        check_eq("midrst_reach7", 32'(got), 32'd1);
        reset     = 1'b0;
        req_valid = 2'b11;
        #1;
        check_all_zero("midrst");
        tick();
        tick();
        reset    = 1'b1;
        req_op   = {OP_LOAD, OP_LOAD};
        req_data = {8'h66, 8'h55};
        @(negedge clk);
        check_eq("postrst_grant", 32'(req_ready), 32'b01);
        tick();
        req_valid = '0;
        wait_done("postrst", 0, 8'h55, 1'b0);

`ifdef COUNTER_SEQ_TIMEOUT_EN
        // Frozen counter trips the watchdog
        issue(1, OP_LOAD, 8'd3);
        wait_done("ld3", 1, 8'd3, 1'b0);
        freeze = 1'b1;
        clear_stats();
        issue(0, OP_COUNTDOWN, 8'd0);
        wait_done("tmo", 0, 8'd3, 1'b1);
        check_eq("tmo_decs", dec_n, TMO - 1);
        freeze = 1'b0;
`endif

        check_eq("strobe_exclusive", excl_viol, 0);
        check_eq("grant_onehot", gnt_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
